nibble_serial_add_ctrl: RTL and testbench

- Sequencer that adds two NIBBLES×4-bit operands by driving an external 4-bit ripple carry adder stage once per clock, least-significant nibble first.
- Sits directly upstream of the 4-bit adder: supplies its a/b/ci inputs and consumes its s/co outputs.
- Chains the carry between nibbles through an internal register.
- Presents the full-width sum and carry-out with a start/busy/done handshake.

---
 rtl/nibble_serial_add_ctrl.sv | 127 ++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial add sequencer driving an external 4-bit adder, LS nibble first.
// Optional signed-overflow flag output enabled by `define ADD_OVF_FLAG_EN.
module nibble_serial_add_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 cin,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
`ifdef ADD_OVF_FLAG_EN
    output logic                 ovf,
`endif
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_ci,
    input  logic [3:0]           add_s,
    input  logic                 add_co
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  partial;
    logic [W-1:0]  partial_next;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          accept;
    logic          last;

    assign accept = start && (state != RUN);
    assign last   = (idx == LAST_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode; adder inputs are held at zero outside RUN
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        add_a  = 4'd0;
        add_b  = 4'd0;
        add_ci = 1'b0;
        case (state)
            RUN: begin
                busy   = 1'b1;
                add_a  = 4'(a_q >> {idx, 2'b00});
                add_b  = 4'(b_q >> {idx, 2'b00});
                add_ci = carry;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Partial sum with the current nibble merged in, used on the completion edge
    always_comb begin
        partial_next = partial;
        partial_next[{idx, 2'b00} +: 4] = add_s;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx     <= '0;
            carry   <= 1'b0;
            partial <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef ADD_OVF_FLAG_EN
            ovf     <= 1'b0;
`endif
        end else if (accept) begin
            a_q   <= op_a;
            b_q   <= op_b;
            carry <= cin;
            idx   <= '0;
        end else if (state == RUN) begin
            partial <= partial_next;
            carry   <= add_co;
            if (last) begin
                sum  <= partial_next;
                cout <= add_co;
`ifdef ADD_OVF_FLAG_EN
                ovf  <= (a_q[W-1] == b_q[W-1]) && (partial_next[W-1] != a_q[W-1]);
`endif
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed scoreboard bench for nibble_serial_add_ctrl with NIBBLES=4 and a behavioural adder.
module tb_nibble_serial_add_ctrl;

    localparam int unsigned NIB = 4;
    localparam int unsigned W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef ADD_OVF_FLAG_EN
    logic         ovf;
`endif
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_ci;
    logic [3:0]   add_s;
    logic         add_co;
    logic [4:0]   add_res;

    int n_cmp = 0;
    int n_err = 0;

    // Entries are {ovf, cout, sum}
    logic [W+1:0] exp_q[$];
    logic [W-1:0] last_sum;
    logic         ci_seen[8];
    int           nb;

    always #5 clk = ~clk;

    assign add_res = 5'(add_a) + 5'(add_b) + 5'(add_ci);
    assign add_s   = add_res[3:0];
    assign add_co  = add_res[4];

    nibble_serial_add_ctrl #(.NIBBLES(NIB)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout),
`ifdef ADD_OVF_FLAG_EN
        .ovf    (ovf),
`endif
        .add_a  (add_a),
        .add_b  (add_b),
        .add_ci (add_ci),
        .add_s  (add_s),
        .add_co (add_co)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                            input bit push);
        logic [W:0] full;
        logic       v;
        full = (W+1)'(a) + (W+1)'(b) + (W+1)'(ci);
        v    = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        if (push) exp_q.push_back({v, full});
        op_a  = a;
        op_b  = b;
        cin   = ci;
        start = 1'b1;
        tick();
        start = 1'b0;
        op_a  = $urandom();
        op_b  = $urandom();
        cin   = 1'b0;
    endtask

    // Run until done, checking busy length and that sum holds, then score the result
    task automatic wait_done(input string tag, input int exp_busy);
        int           cyc;
        logic [W+1:0] e;
        cyc = 0;
        nb  = 0;
        while (!done && cyc < 12) begin
            if (busy) begin
                if (nb < 8) ci_seen[nb] = add_ci;
                nb++;
                chk({tag, "_sum_hold"}, 32'(sum), 32'(last_sum));
            end
            tick();
            cyc++;
        end
        chk({tag, "_done_seen"}, 32'(done), 32'd1);
        chk({tag, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_sum"}, 32'(sum), 32'(e[W-1:0]));
            chk({tag, "_cout"}, 32'(cout), 32'(e[W]));
`ifdef ADD_OVF_FLAG_EN
            chk({tag, "_ovf"}, 32'(ovf), 32'(e[W+1]));
`endif
            last_sum = e[W-1:0];
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        op_a     = '0;
        op_b     = '0;
        cin      = 1'b0;
        last_sum = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_add_a", 32'(add_a), 32'd0);
        tick();

        start_op(16'h1234, 16'h0FCD, 1'b0, 1'b1);
        wait_done("basic", 4);
        tick();
        chk("idle_after_done", 32'(done), 32'd0);
        chk("idle_sum_hold", 32'(sum), 32'h2201);

        // Previous result must hold while the ripple case runs
        start_op(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        wait_done("ripple", 4);
        chk("ripple_ci0", 32'(ci_seen[0]), 32'd0);
        chk("ripple_ci1", 32'(ci_seen[1]), 32'd1);
        chk("ripple_ci2", 32'(ci_seen[2]), 32'd1);
        chk("ripple_ci3", 32'(ci_seen[3]), 32'd1);
        tick();

        start_op(16'h0000, 16'h0000, 1'b1, 1'b1);
        wait_done("cin_only", 4);
        tick();
        start_op(16'h7FFF, 16'h0001, 1'b0, 1'b1);
        wait_done("signed_ovf", 4);
        tick();

        // start during RUN is ignored
        start_op(16'h5555, 16'h1111, 1'b0, 1'b1);
        op_a  = 16'hAAAA;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("ignored_start", 3);

        // back-to-back accept from DONE
        start_op(16'h8000, 16'h8000, 1'b1, 1'b1);
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_done("b2b", 4);
        tick();

        // reset in the third RUN cycle abandons the operation
        start_op(16'h1234, 16'h1111, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 8; i++) begin
                if (done || busy) seen++;
                tick();
            end
            chk("midrst_no_done", 32'(seen), 32'd0);
        end
        last_sum = '0;

        start_op(16'h0F0F, 16'h0101, 1'b0, 1'b1);
        wait_done("post_reset", 4);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
